// File: rtl/decoder_scan_pkg.sv
// Shared mode codes and sweep FSM encoding for the scanning one-hot decoder.
package decoder_scan_pkg;

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_SCAN   = 2'b01;
    localparam logic [1:0] MODE_SWEEP  = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SWEEP = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/decoder_scan_n_if.sv
// Control inputs and display outputs of decoder_scan_n, grouped as one bus.
interface decoder_scan_n_if #(
    parameter int N       = 3,
    parameter int DWELL_W = 8
);
    logic                 EN;
    logic [1:0]           MODE;
    logic [N-1:0]         A;
    logic [DWELL_W-1:0]   DWELL;
    logic                 START;
    logic [(2**N)-1:0]    B;
    logic [N-1:0]         IDX;
    logic                 BUSY;
    logic                 DONE;
    logic                 WRAP;

    modport master (
        output EN, MODE, A, DWELL, START,
        input  B, IDX, BUSY, DONE, WRAP
    );

    modport slave (
        input  EN, MODE, A, DWELL, START,
        output B, IDX, BUSY, DONE, WRAP
    );
endinterface

// File: rtl/decoder_scan_n_dwell_timer.sv
// Dwell counter: counts 0..limit while running, ticks on compare-equal and restarts.
module dwell_timer #(
    parameter int DWELL_W = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               run,
    input  logic               clear,
    input  logic [DWELL_W-1:0] limit,
    output logic               tick
);

    logic [DWELL_W-1:0] cnt_q, cnt_d;

    // Limit is compared live; a lowered limit is reached again after natural wrap.
    assign tick = run && !clear && (cnt_q == limit);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = tick ? '0 : cnt_q + DWELL_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/decoder_scan_n.sv
// N-to-2^N registered one-hot decoder with direct, auto-scan, one-shot sweep and hold modes.
module decoder_scan_n
    import decoder_scan_pkg::*;
#(
    parameter int N       = 3,
    parameter int DWELL_W = 8
) (
    input  logic CLK,
    input  logic RST,
    decoder_scan_n_if.slave bus
);

    localparam int W = 2**N;
    localparam logic [N-1:0] IDX_MAX = '1;

    function automatic logic [W-1:0] onehot(input logic [N-1:0] i);
        onehot = W'(1) << i;
    endfunction

    state_e         state_q, state_d;
    logic [N-1:0]   idx_q, idx_d;
    logic [W-1:0]   b_q, b_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           wrap_q, wrap_d;
    logic           run_c, clear_c, tick;

    // Timer controls depend only on inputs and state, never on tick.
    always_comb begin
        run_c   = 1'b0;
        clear_c = 1'b0;
        if (bus.EN) begin
            run_c   = (bus.MODE == MODE_SCAN) ||
                      (bus.MODE == MODE_SWEEP && state_q == ST_SWEEP);
            clear_c = (bus.MODE == MODE_DIRECT) ||
                      (bus.MODE == MODE_SWEEP && state_q == ST_IDLE && bus.START);
        end
    end

    dwell_timer #(.DWELL_W(DWELL_W)) u_dwell (
        .CLK   (CLK),
        .RST   (RST),
        .run   (run_c),
        .clear (clear_c),
        .limit (bus.DWELL),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        b_d     = b_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        if (!bus.EN) begin
            b_d = '0;
        end else begin
            case (bus.MODE)
                MODE_DIRECT: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    idx_d   = bus.A;
                    b_d     = onehot(bus.A);
                end
                MODE_SCAN: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    if (tick) begin
                        idx_d  = idx_q + N'(1);
                        wrap_d = (idx_q == IDX_MAX);
                    end
                    b_d = onehot(idx_d);
                end
                MODE_SWEEP: begin
                    case (state_q)
                        ST_IDLE: begin
                            b_d    = '0;
                            busy_d = 1'b0;
                            if (bus.START) begin
                                state_d = ST_SWEEP;
                                idx_d   = bus.A;
                                busy_d  = 1'b1;
                                b_d     = onehot(bus.A);
                            end
                        end
                        ST_SWEEP: begin
                            // Last index finishing its dwell ends the sweep; START is ignored here.
                            if (tick && idx_q == IDX_MAX) begin
                                state_d = ST_DONE;
                                b_d     = '0;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                            end else begin
                                if (tick) idx_d = idx_q + N'(1);
                                b_d = onehot(idx_d);
                            end
                        end
                        default: begin
                            state_d = ST_IDLE;
                            b_d     = '0;
                            busy_d  = 1'b0;
                        end
                    endcase
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            b_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.B    = b_q;
    assign bus.IDX  = idx_q;
    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;
    assign bus.WRAP = wrap_q;

endmodule
